// File: rtl/move_executor_if.sv
// Move handshake and stepper-pin bundle between the move sequencer and move_executor.
// master = sequencer side, slave = executor side.
interface move_executor_if;
  logic       start_move;
  logic [3:0] next_move;
  logic       move_done;
  logic       busy;
  logic       bad_move;
  logic [5:0] step;
  logic [5:0] dir;
  logic [5:0] motor_en;

  modport master (
    output start_move, next_move,
    input  move_done, busy, bad_move, step, dir, motor_en
  );

  modport slave (
    input  start_move, next_move,
    output move_done, busy, bad_move, step, dir, motor_en
  );
endinterface

// File: rtl/move_executor.sv
// Executes one quarter-turn move per accepted start_move on one of six face steppers.
// Optional acceleration ramp on the first/last RAMP_STEPS steps: define MOVE_EXECUTOR_RAMP_EN.
module move_executor #(
  parameter int unsigned STEPS_PER_QTR = 50,
  parameter int unsigned STEP_PERIOD   = 2000,
  parameter int unsigned STEP_HIGH     = 200,
  parameter int unsigned SETTLE_CYCLES = 100000,
  parameter int unsigned RAMP_STEPS    = 5
) (
  input logic           clock,
  input logic           reset,
  move_executor_if.slave move_io
);

`ifdef MOVE_EXECUTOR_RAMP_EN
  localparam bit          RampEn    = 1'b1;
  localparam int unsigned MaxPeriod = 2 * STEP_PERIOD;
`else
  localparam bit          RampEn    = 1'b0;
  localparam int unsigned MaxPeriod = STEP_PERIOD;
`endif

  localparam int unsigned StepW = (STEPS_PER_QTR > 1) ? $clog2(STEPS_PER_QTR) : 1;
  localparam int unsigned PerW  = (MaxPeriod > 1) ? $clog2(MaxPeriod) : 1;
  localparam int unsigned SetW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [StepW-1:0] LastStep   = StepW'(STEPS_PER_QTR - 1);
  localparam logic [PerW-1:0]  HighLast   = PerW'(STEP_HIGH - 1);
  localparam logic [PerW-1:0]  PerLast    = PerW'(STEP_PERIOD - 1);
  localparam logic [PerW-1:0]  RampLast   = PerW'(2 * STEP_PERIOD - 1);
  localparam logic [SetW-1:0]  SettleLast = SetW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {StIdle, StStepHi, StStepLo, StSettle, StDone} state_e;

  state_e           state_q, state_d;
  logic [PerW-1:0]  per_q, per_d;
  logic [StepW-1:0] step_q, step_d;
  logic [SetW-1:0]  set_q, set_d;
  logic             lead_q, lead_d;
  logic             act_q, act_d;
  logic             bad_q, bad_d;
  logic [5:0]       en_q, en_d;
  logic [5:0]       dir_q, dir_d;

  logic [3:0]       code_m1;
  logic [2:0]       face;
  logic             is_ramp;
  logic [PerW-1:0]  per_last;

  assign code_m1  = move_io.next_move - 4'd1;
  assign face     = code_m1[3:1];
  assign is_ramp  = RampEn && ((32'(step_q) < RAMP_STEPS) ||
                               (32'(step_q) >= STEPS_PER_QTR - RAMP_STEPS));
  assign per_last = is_ramp ? RampLast : PerLast;

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    step_d  = step_q;
    set_d   = set_q;
    lead_d  = lead_q;
    act_d   = act_q;
    bad_d   = bad_q;
    en_d    = en_q;
    dir_d   = dir_q;

    unique case (state_q)
      StIdle: begin
        if (move_io.start_move) begin
          // One lead-in cycle in StStepLo so the first step rises one edge after accept.
          state_d = StStepLo;
          lead_d  = 1'b1;
          per_d   = '0;
          step_d  = '0;
          bad_d   = (move_io.next_move >= 4'd13);
          act_d   = (move_io.next_move != 4'd0) && (move_io.next_move <= 4'd12);
          if ((move_io.next_move != 4'd0) && (move_io.next_move <= 4'd12)) begin
            en_d  = 6'b000001 << face;
            dir_d = {5'b0, code_m1[0]} << face;
          end else begin
            en_d  = '0;
            dir_d = '0;
          end
        end
      end
      StStepHi: begin
        per_d = per_q + 1'b1;
        if (per_q == HighLast) begin
          state_d = StStepLo;
        end
      end
      StStepLo: begin
        if (lead_q) begin
          lead_d  = 1'b0;
          per_d   = '0;
          state_d = act_q ? StStepHi : StDone;
        end else if (per_q == per_last) begin
          per_d = '0;
          if (step_q == LastStep) begin
            set_d   = '0;
            state_d = (SETTLE_CYCLES == 0) ? StDone : StSettle;
          end else begin
            step_d  = step_q + 1'b1;
            state_d = StStepHi;
          end
        end else begin
          per_d = per_q + 1'b1;
        end
      end
      StSettle: begin
        set_d = set_q + 1'b1;
        if (set_q == SettleLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d == StDone) begin
      en_d  = '0;
      dir_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      per_q   <= '0;
      step_q  <= '0;
      set_q   <= '0;
      lead_q  <= 1'b0;
      act_q   <= 1'b0;
      bad_q   <= 1'b0;
      en_q    <= '0;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      step_q  <= step_d;
      set_q   <= set_d;
      lead_q  <= lead_d;
      act_q   <= act_d;
      bad_q   <= bad_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
    end
  end

  assign move_io.step      = (state_q == StStepHi) ? en_q : 6'b0;
  assign move_io.dir       = dir_q;
  assign move_io.motor_en  = en_q;
  assign move_io.busy      = (state_q != StIdle);
  assign move_io.move_done = (state_q == StDone);
  assign move_io.bad_move  = bad_q;

endmodule

// File: tb/tb_move_executor.sv
// Scoreboard bench for move_executor: random moves, mid-move starts and resets against a
// timeline model of expected step rises, move_done edges and output windows.
module tb_move_executor;
  localparam int unsigned Spq    = 4;
  localparam int unsigned Period = 4;
  localparam int unsigned High   = 2;
  localparam int unsigned Settle = 3;
  localparam int unsigned Ramp   = 1;
`ifdef MOVE_EXECUTOR_RAMP_EN
  localparam bit RampOn = 1'b1;
`else
  localparam bit RampOn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  move_executor_if io ();

  move_executor #(
    .STEPS_PER_QTR(Spq),
    .STEP_PERIOD  (Period),
    .STEP_HIGH    (High),
    .SETTLE_CYCLES(Settle),
    .RAMP_STEPS   (Ramp)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .move_io(io.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int e; int face;} rise_t;
  typedef struct {int st; int busy_end; int en_end; logic [5:0] en; logic [5:0] dir;} win_t;

  int    n_chk  = 0;
  int    n_fail = 0;
  int    done_q[$];
  rise_t rise_q[$];
  win_t  cur_w  = '{0, -1, 0, 6'b0, 6'b0};
  win_t  prev_w = '{0, -1, 0, 6'b0, 6'b0};
  int    busy_end = -1;
  logic  bad_prev = 1'b0, bad_cur = 1'b0;
  int    bad_from = 0;
  int    rst_edge = 0;
  bit    mon_on   = 1'b0;
  logic [5:0] prev_step = 6'b0;
  int    last_rise[6];

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  function automatic int period_of(input int k);
    if (RampOn && (k < int'(Ramp) || k >= int'(Spq - Ramp))) return 2 * Period;
    return Period;
  endfunction

  function automatic bit in_busy(input win_t w, input int e);
    return (e >= w.st) && (e <= w.busy_end);
  endfunction

  function automatic bit in_en(input win_t w, input int e);
    return (e >= w.st) && (e < w.en_end);
  endfunction

  // Monitor: sampled on the falling edge, cyc is the index of the last rising edge.
  always @(negedge clock) begin
    if (mon_on) begin
      int e;
      logic [5:0] exp_en, exp_dir;
      rise_t r;
      e = cyc;
      while (done_q.size() > 0 && done_q[0] < e) begin
        check("move_done_missed", -1, done_q[0]);
        void'(done_q.pop_front());
      end
      if (io.move_done) begin
        if (done_q.size() == 0) check("move_done_spurious", e, -1);
        else check("move_done_edge", e, done_q.pop_front());
      end
      while (rise_q.size() > 0 && rise_q[0].e < e) begin
        check("step_rise_missed", -1, rise_q[0].e);
        void'(rise_q.pop_front());
      end
      for (int f = 0; f < 6; f++) begin
        if (io.step[f] && !prev_step[f]) begin
          if (rise_q.size() == 0) begin
            check("step_rise_spurious", e, -1);
          end else begin
            r = rise_q.pop_front();
            check("step_rise_edge", e, r.e);
            check("step_rise_face", f, r.face);
          end
          last_rise[f] = e;
        end
        if (!io.step[f] && prev_step[f] && e != rst_edge)
          check("step_high_width", e - last_rise[f], int'(High));
      end
      prev_step = io.step;
      check("busy", int'(io.busy), int'(in_busy(prev_w, e) || in_busy(cur_w, e)));
      exp_en  = in_en(prev_w, e) ? prev_w.en  : (in_en(cur_w, e) ? cur_w.en  : 6'b0);
      exp_dir = in_en(prev_w, e) ? prev_w.dir : (in_en(cur_w, e) ? cur_w.dir : 6'b0);
      check("motor_en", int'(io.motor_en), int'(exp_en));
      check("dir", int'(io.dir), int'(exp_dir));
      check("bad_move", int'(io.bad_move), int'((e >= bad_from) ? bad_cur : bad_prev));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive start_move for the next rising edge and record the model's expectations.
  task automatic issue(input logic [3:0] code);
    int e, t, face, done;
    logic ccw;
    e = cyc + 1;
    io.start_move = 1'b1;
    io.next_move  = code;
    if (e > busy_end) begin
      prev_w   = cur_w;
      cur_w.st = e;
      bad_prev = bad_cur;
      bad_cur  = (code >= 4'd13);
      bad_from = e;
      if (code >= 4'd1 && code <= 4'd12) begin
        face = (int'(code) - 1) / 2;
        ccw  = ((int'(code) - 1) % 2) == 1;
        t    = e + 1;
        for (int k = 0; k < int'(Spq); k++) begin
          rise_q.push_back('{t, face});
          t += period_of(k);
        end
        done         = t + int'(Settle);
        cur_w.en     = 6'b000001 << face;
        cur_w.dir    = ccw ? cur_w.en : 6'b0;
        cur_w.en_end = done;
      end else begin
        done         = e + 1;
        cur_w.en     = 6'b0;
        cur_w.dir    = 6'b0;
        cur_w.en_end = e;
      end
      cur_w.busy_end = done;
      busy_end       = done;
      done_q.push_back(done);
    end
    tick();
    io.start_move = 1'b0;
    io.next_move  = 4'($urandom_range(0, 15));
  endtask

  // Synchronous reset sampled on exactly one edge; later expectations are dropped.
  task automatic do_reset();
    int r;
    int dq[$];
    rise_t rq[$];
    r = cyc + 1;
    reset = 1'b1;
    foreach (done_q[i]) if (done_q[i] < r) dq.push_back(done_q[i]);
    foreach (rise_q[i]) if (rise_q[i].e < r) rq.push_back(rise_q[i]);
    done_q = dq;
    rise_q = rq;
    if (cur_w.busy_end >= r) cur_w.busy_end = r - 1;
    if (cur_w.en_end > r) cur_w.en_end = r;
    if (busy_end >= r) busy_end = r - 1;
    bad_prev = bad_cur;
    bad_cur  = 1'b0;
    bad_from = r;
    rst_edge = r;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc <= busy_end) tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] code;
    foreach (last_rise[i]) last_rise[i] = 0;
    io.start_move = 1'b0;
    io.next_move  = 4'd0;
    repeat (3) @(posedge clock);
    #1;
    reset    = 1'b0;
    rst_edge = cyc;
    mon_on   = 1'b1;
    tick();

    issue(4'd1);  wait_idle();
    issue(4'd12); wait_idle();
    issue(4'd0);  wait_idle();
    issue(4'd14); wait_idle();
    repeat (2) tick();
    issue(4'd1);                 // accepted at N
    repeat (5) tick();
    issue(4'd3);                 // N+6, ignored
    wait_idle();
    issue(4'd1);                 // accepted at N
    repeat (5) tick();
    issue(4'd3);                 // N+6, ignored
    do_reset();                  // N+7
    repeat (2) tick();
    issue(4'd2);                 // N+10
    while (cyc < busy_end - 1) tick();
    issue(4'd5);                 // lands on the move_done edge, ignored
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      code = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 24)) tick();
      if ($urandom_range(0, 11) == 0) do_reset();
      else issue(code);
    end
    wait_idle();
    repeat (4) tick();

    check("done_queue_drained", done_q.size(), 0);
    check("rise_queue_drained", rise_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
